// File: rtl/core_manage_types.sv
// rtl/core_manage_types.sv - shared core-management types and constants
// Command codes and the management address are consumed by requesters and the bench.
package core_manage_types;

   localparam int unsigned CMWA_TIMEOUT_DEF = 16;

   localparam logic [31:0] WADDR_MAN = 32'h0000_0040;

   localparam logic [31:0] HALTC0  = 32'h0000_0100;
   localparam logic [31:0] HALTC1  = 32'h0000_0101;
   localparam logic [31:0] HALTC2  = 32'h0000_0102;
   localparam logic [31:0] HALTC3  = 32'h0000_0103;
   localparam logic [31:0] NHALTC0 = 32'h0000_0200;
   localparam logic [31:0] NHALTC1 = 32'h0000_0201;
   localparam logic [31:0] NHALTC2 = 32'h0000_0202;
   localparam logic [31:0] NHALTC3 = 32'h0000_0203;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      SETTLE,
      WAIT_DONE,
      RESP
   } cmwa_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick, searching upward from rr_ptr with wrap
module rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [$clog2(NUM_REQ)-1:0] winner,
   output logic                       valid
);

   localparam int IW = $clog2(NUM_REQ);

   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      valid  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Wrap explicitly so non-power-of-two NUM_REQ stays in range.
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!valid && req[idx[IW-1:0]]) begin
            winner = idx[IW-1:0];
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/core_mgmt_write_arbiter.sv
// rtl/core_mgmt_write_arbiter.sv - round-robin arbiter for the management-register write port
// One write in flight; issue pulse, settle cycle, wait for w_done or time out, then respond.
module core_mgmt_write_arbiter
   import core_manage_types::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = CMWA_TIMEOUT_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pwr,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*32-1:0]      req_addr,
   input  logic [NUM_REQ*32-1:0]      req_data,
   output logic [NUM_REQ-1:0]         req_done,
   output logic [NUM_REQ-1:0]         req_err,
   output logic                       m_awvalid,
   output logic                       m_wvalid,
   output logic [31:0]                m_waddr,
   output logic [31:0]                m_wdata,
   input  logic                       m_wdone,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);

   cmwa_state_t   state;
   cmwa_state_t   state_nx;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] pick_id;
   logic          pick_vld;
   logic [CW-1:0] wait_cnt;
   logic          timeout_hit;
   logic          err_q;
   logic [31:0]   hold_addr;
   logic [31:0]   hold_data;
   logic [31:0]   addr_sel;
   logic [31:0]   data_sel;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (pick_id),
      .valid  (pick_vld)
   );

   always_comb begin
      addr_sel = '0;
      data_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_id == IW'(i)) begin
            addr_sel = req_addr[32*i +: 32];
            data_sel = req_data[32*i +: 32];
         end
      end
   end

   // Last WAIT_DONE cycle is the one where the incremented count would reach TIMEOUT-1.
   assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (pwr && pick_vld)        state_nx = ISSUE;
         ISSUE:     if (pwr)                    state_nx = SETTLE;
         SETTLE:                                state_nx = WAIT_DONE;
         WAIT_DONE: if (m_wdone || timeout_hit) state_nx = RESP;
         RESP:                                  state_nx = IDLE;
         default:                               state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_addr <= '0;
         hold_data <= '0;
         gnt_id    <= '0;
         rr_ptr    <= '0;
         wait_cnt  <= '0;
         err_q     <= 1'b0;
      end else begin
         if (state == IDLE && state_nx == ISSUE) begin
            hold_addr <= addr_sel;
            hold_data <= data_sel;
            gnt_id    <= pick_id;
         end
         if (state == SETTLE) begin
            wait_cnt <= '0;
         end else if (state == WAIT_DONE && !m_wdone) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (state == WAIT_DONE) begin
            err_q <= !m_wdone;
         end
         if (state == RESP) begin
            rr_ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
         end
      end
   end

   // Valids are held off while power is low so the pulse waits in ISSUE.
   always_comb begin
      m_awvalid = (state == ISSUE) && pwr;
      m_wvalid  = (state == ISSUE) && pwr;
      busy      = (state != IDLE);
      req_done  = '0;
      req_err   = '0;
      if (state == RESP) begin
         if (err_q) begin
            req_err[gnt_id] = 1'b1;
         end else begin
            req_done[gnt_id] = 1'b1;
         end
      end
   end

   assign m_waddr = hold_addr;
   assign m_wdata = hold_data;

endmodule

// File: tb/tb_core_mgmt_write_arbiter.sv
// tb/tb_core_mgmt_write_arbiter.sv - self-checking bench for core_mgmt_write_arbiter
// Transaction-level model: round-robin order from held requests, latency from downstream delay.
module tb_core_mgmt_write_arbiter;
   import core_manage_types::*;

   localparam int N = 4;
   localparam int T = CMWA_TIMEOUT_DEF;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            pwr = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*32-1:0] req_addr = '0;
   logic [N*32-1:0] req_data = '0;
   logic [N-1:0]    req_done;
   logic [N-1:0]    req_err;
   logic            m_awvalid;
   logic            m_wvalid;
   logic [31:0]     m_waddr;
   logic [31:0]     m_wdata;
   logic            m_wdone = 1'b1;
   logic            busy;
   logic [1:0]      gnt_id;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int mptr    = 0;
   int dly [N];
   bit halt [N];

   core_mgmt_write_arbiter #(.NUM_REQ(N), .TIMEOUT(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .pwr       (pwr),
      .req       (req),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_done  (req_done),
      .req_err   (req_err),
      .m_awvalid (m_awvalid),
      .m_wvalid  (m_wvalid),
      .m_waddr   (m_waddr),
      .m_wdata   (m_wdata),
      .m_wdone   (m_wdone),
      .busy      (busy),
      .gnt_id    (gnt_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Downstream: w_done low for the cycle after an accepted write plus dly[addr[1:0]] cycles.
   initial begin : downstream
      int          lowcnt;
      bit          acc;
      logic [31:0] a;
      logic [31:0] d;
      lowcnt = 0;
      forever begin
         @(negedge clk);
         acc = m_awvalid && m_wvalid;
         a   = m_waddr;
         d   = m_wdata;
         if (acc && a == WADDR_MAN) begin
            if (d[31:8] == 24'h1) halt[d[1:0]] = 1'b1;
            if (d[31:8] == 24'h2) halt[d[1:0]] = 1'b0;
         end
         @(posedge clk);
         #1;
         if (rst) lowcnt = 0;
         else if (acc) lowcnt = 1 + dly[a[1:0]];
         if (lowcnt > 0) begin
            m_wdone = 1'b0;
            lowcnt--;
         end else begin
            m_wdone = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && (req_done | req_err) != '0) begin
         chk("resp_onehot", 64'($countones({req_done, req_err})), 1);
      end
   end

   function automatic int next_rr(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++) begin
         if (m[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic wait_issue(output int at);
      at = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_awvalid) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("issue_timeout", 0, 1);
   endtask

   task automatic wait_resp(output int at, output int id, output bit err);
      at  = -1;
      id  = -1;
      err = 1'b0;
      for (int i = 0; i < T + 12; i++) begin
         @(negedge clk);
         if ((req_done | req_err) != '0) begin
            at  = cyc;
            err = (req_err != '0);
            for (int j = 0; j < N; j++) if (req_done[j] || req_err[j]) id = j;
            break;
         end
      end
      if (at < 0) chk("resp_timeout", 0, 1);
   endtask

   task automatic xact(input int w, input int prev, input bit drop, output int t_rsp);
      int t_iss;
      int rid;
      bit rerr;
      bit eerr;
      wait_issue(t_iss);
      chk("gnt_id", 64'(gnt_id), 64'(w));
      chk("m_waddr", 64'(m_waddr), 64'(req_addr[32*w +: 32]));
      chk("m_wdata", 64'(m_wdata), 64'(req_data[32*w +: 32]));
      chk("wvalid", 64'(m_wvalid), 1);
      if (prev >= 0) chk("b2b_gap", 64'(t_iss - prev), 2);
      if (drop) req[w] = 1'b0;
      @(negedge clk);
      chk("pulse_len", 64'({m_awvalid, m_wvalid}), 0);
      wait_resp(t_rsp, rid, rerr);
      eerr = dly[w] > T - 2;
      chk("rsp_id", 64'(rid), 64'(w));
      chk("rsp_kind", 64'(rerr), 64'(eerr));
      chk("rsp_lat", 64'(t_rsp - t_iss), eerr ? 64'(T + 1) : 64'(dly[w] + 3));
   endtask

   task automatic run_round(input logic [N-1:0] mask, input int ntx, input bit keep);
      logic [N-1:0] held;
      logic [31:0]  r;
      int           w;
      int           prev;
      int           tr;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         r = $urandom();
         req_addr[32*i +: 32] = {r[31:2], 2'(i)};
         req_data[32*i +: 32] = $urandom();
      end
      held = mask;
      req  = mask;
      prev = -1;
      for (int k = 0; k < ntx; k++) begin
         w = next_rr(held, mptr);
         xact(w, prev, 1'b0, tr);
         prev = tr;
         if (!keep) held[w] = 1'b0;
         req  = held;
         mptr = (w + 1) % N;
      end
      req = '0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int          t;
      bit          seen;
      logic [3:0]  mask;
      logic [31:0] r;
      for (int i = 0; i < N; i++) begin
         dly[i]  = 0;
         halt[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_gnt", 64'(gnt_id), 0);
      chk("rst_valid", 64'({m_awvalid, m_wvalid}), 0);
      chk("rst_addr", 64'(m_waddr), 0);
      chk("rst_data", 64'(m_wdata), 0);
      chk("rst_rsp", 64'({req_done, req_err}), 0);
      rst = 1'b0;
      pwr = 1'b1;
      @(negedge clk);

      // single request carrying a real command
      halt[1]         = 1'b1;
      req_addr[31:0]  = WADDR_MAN;
      req_data[31:0]  = NHALTC1;
      req             = 4'b0001;
      xact(0, -1, 1'b0, t);
      req  = '0;
      mptr = 1;
      chk("halt1_cleared", 64'(halt[1]), 0);

      // fairness from a fresh reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      mptr = 0;
      run_round(4'b1111, 8, 1'b1);

      // power low blocks grant
      @(negedge clk);
      pwr = 1'b0;
      req = 4'b0010;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (m_awvalid || busy) seen = 1'b1;
      end
      chk("pwr_off_idle", 64'(seen), 0);
      pwr = 1'b1;
      xact(1, -1, 1'b0, t);
      req  = '0;
      mptr = 2;

      // power drops right after grant: pulse held until it returns
      @(negedge clk);
      req = 4'b0100;
      @(posedge clk);
      #1 pwr = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (m_awvalid || m_wvalid) seen = 1'b1;
      end
      chk("pwr_hold_novalid", 64'(seen), 0);
      chk("pwr_hold_busy", 64'(busy), 1);
      @(posedge clk);
      #1 pwr = 1'b1;
      xact(2, -1, 1'b0, t);
      req  = '0;
      mptr = 3;

      // timeout on 3, then 0 served normally
      dly[3] = T + 3;
      run_round(4'b1001, 2, 1'b0);
      dly[3] = 0;

      // both sides of the timeout boundary
      dly[0] = T - 2;
      dly[1] = T - 1;
      run_round(4'b0011, 2, 1'b0);
      dly[0] = 0;
      dly[1] = 0;

      // reset during WAIT_DONE, rr pointer must restart at 0
      run_round(4'b0010, 1, 1'b0);
      @(negedge clk);
      r              = $urandom();
      req_addr[31:0] = {r[31:2], 2'b00};
      dly[0]         = T + 3;
      req            = 4'b0001;
      wait_issue(t);
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", 64'(busy), 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(busy), 0);
      chk("mid_rst_valid", 64'({m_awvalid, m_wvalid}), 0);
      chk("mid_rst_gnt", 64'(gnt_id), 0);
      chk("mid_rst_addr", 64'(m_waddr), 0);
      chk("mid_rst_data", 64'(m_wdata), 0);
      req  = '0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if ((req_done | req_err) != '0 || busy) seen = 1'b1;
      end
      chk("mid_rst_quiet", 64'(seen), 0);
      rst    = 1'b0;
      dly[0] = 0;
      mptr   = 0;
      run_round(4'b1010, 2, 1'b0);

      // requester 3 drops its request right after grant
      @(negedge clk);
      req_data[127:96] = $urandom();
      req              = 4'b1000;
      xact(3, -1, 1'b1, t);
      mptr = 0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (m_awvalid || busy || req_done != '0) seen = 1'b1;
      end
      chk("no_regrant", 64'(seen), 0);

      // randomized rounds
      repeat (12) begin
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(0, T + 1));
         run_round(mask, $countones(mask), 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
